// File: rtl/aes_pkg.sv
// aes_pkg: AES widths, round constants and the inverse key schedule FSM states.
package aes_pkg;
    localparam int AES_KEY_W      = 128;
    localparam int AES_WORD_W     = 32;
    localparam int NUM_ROUNDS_128 = 10;

    typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} inv_ks_state_t;

    function automatic logic [AES_WORD_W-1:0] rcon(input logic [3:0] i);
        logic [7:0] rc;
        case (i)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h0};
    endfunction
endpackage

// File: rtl/inv_key_schedule_if.sv
// inv_key_schedule_if: key-in / round-key-out stream handshakes plus synchronous abort.
interface inv_key_schedule_if import aes_pkg::*;;
    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic [AES_KEY_W-1:0] in_key;
    logic                 out_valid;
    logic                 out_ready;
    logic [AES_KEY_W-1:0] out_key;
    logic [3:0]           out_round;
    logic                 out_last;

    modport master (
        output clear, in_valid, in_key, out_ready,
        input  in_ready, out_valid, out_key, out_round, out_last
    );

    modport slave (
        input  clear, in_valid, in_key, out_ready,
        output in_ready, out_valid, out_key, out_round, out_last
    );
endinterface

// File: rtl/inv_key_round.sv
// inv_key_round: undoes one AES-128 key expansion round, round i key -> round i-1 key.
module inv_key_round import aes_pkg::*; (
    input  logic [AES_KEY_W-1:0] round_key,
    input  logic [3:0]           round_idx,
    output logic [AES_KEY_W-1:0] prev_key
);
    logic [AES_WORD_W-1:0] w_w0, w_w1, w_w2, w_w3, w_w1p, w_w2p, w_w3p, w_sub;

    assign {w_w0, w_w1, w_w2, w_w3} = round_key;
    assign w_w3p = w_w3 ^ w_w2;
    assign w_w2p = w_w2 ^ w_w1;
    assign w_w1p = w_w1 ^ w_w0;

    // w3' is the previous round's last word, which fed SubWord(RotWord()) going forward
    sub_words u_sub (
        .i_word ({w_w3p[23:0], w_w3p[31:24]}),
        .o_word (w_sub)
    );

    assign prev_key = {w_w0 ^ w_sub ^ rcon(round_idx), w_w1p, w_w2p, w_w3p};
endmodule

// File: rtl/sub_words.sv
// sub_words: applies the AES S-box to each byte of a 32-bit word.
module sub_words import aes_pkg::*; (
    input  logic [AES_WORD_W-1:0] i_word,
    output logic [AES_WORD_W-1:0] o_word
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    for (genvar g = 0; g < 4; g++) begin : g_byte
        assign o_word[8*g +: 8] = SBOX[i_word[8*g +: 8]];
    end
endmodule

// File: rtl/inv_key_schedule.sv
// inv_key_schedule: streams AES-128 round keys 10 down to 0 from the round-10 key,
// running the expansion backwards one round per accepted beat.
module inv_key_schedule import aes_pkg::*; #(
    parameter int NUM_ROUNDS = NUM_ROUNDS_128
) (
    input  logic               clk,
    input  logic               rst,
    inv_key_schedule_if.slave  bus
);
    if (NUM_ROUNDS != NUM_ROUNDS_128) begin : g_bad_rounds
        $error("inv_key_schedule supports only NUM_ROUNDS = 10");
    end

    inv_ks_state_t        r_state;
    logic [AES_KEY_W-1:0] r_key;
    logic [AES_KEY_W-1:0] w_prev;
    logic [3:0]           r_round;

    inv_key_round u_round (
        .round_key (r_key),
        .round_idx (r_round),
        .prev_key  (w_prev)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_key   <= '0;
            r_round <= '0;
        end else if (bus.clear) begin
            r_state <= IDLE;
            r_round <= '0;
        end else if (r_state == IDLE && bus.in_valid) begin
            r_state <= EMIT;
            r_key   <= bus.in_key;
            r_round <= 4'(NUM_ROUNDS);
        end else if (r_state == EMIT && bus.out_ready) begin
            if (r_round == 4'd0)
                r_state <= IDLE;
            else begin
                r_key   <= w_prev;
                r_round <= r_round - 4'd1;
            end
        end
    end

    assign bus.in_ready  = r_state == IDLE;
    assign bus.out_valid = r_state == EMIT;
    assign bus.out_key   = r_key;
    assign bus.out_round = r_round;
    assign bus.out_last  = r_state == EMIT && r_round == 4'd0;
endmodule
